serialdiv: RTL and testbench

Sequential restoring divider: the inverse of the bit-serial multiplier datapath in the arithmetic examples. It takes a 16-bit unsigned dividend and an 8-bit unsigned divisor and produces one quotient bit per clock, MSB first, under a start/busy/done handshake. It returns a 16-bit quotient and an 8-bit remainder. It sits beside the multiplier as a standalone arithmetic unit driven by a simple controller or testbench.

---
 rtl/arith_pkg.sv | 16 +
 rtl/serialdiv_if.sv | 34 +++
 rtl/divstep.sv | 26 ++
 rtl/serialdiv.sv | 110 +++++++++++
 tb/tb_serialdiv.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic package for the serial divider.
// Contents:
//   div_state_t     FSM state encoding {IDLE, RUN, DONE}
//   DIV_DW, DIV_VW  default dividend/quotient and divisor/remainder widths
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_DW = 16;
    localparam int DIV_VW = 8;

endpackage

// File: rtl/serialdiv_if.sv
// Handshake and operand/result bundle for the serial divider.
// Signals:
//   start  request pulse, sampled by the divider only while idle
//   a, b   dividend (DW) and divisor (VW), sampled with start
//   busy   high while an operation is running or finishing
//   done   one-cycle completion pulse
//   q, r   quotient (DW) and remainder (VW), held until the next accepted start
//   dz     divide-by-zero flag, held like q
// Modports: master drives the request, slave (the divider) drives results.
interface serialdiv_if
    import arith_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
);
    logic          start;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic          busy;
    logic          done;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;

    modport master (
        output start, a, b,
        input  busy, done, q, r, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, dz
    );
endinterface

// File: rtl/divstep.sv
// One combinational restoring-division step.
// Ports:
//   pr_i    incoming partial remainder (VW bits, always < d_i)
//   din_i   next dividend bit, shifted into the remainder LSB
//   d_i     divisor
//   pr_o    next partial remainder
//   qbit_o  quotient bit produced by this step
// Usable stand-alone as one row of an unrolled divider.
module divstep #(
    parameter int VW = 8
) (
    input  logic [VW-1:0] pr_i,
    input  logic          din_i,
    input  logic [VW-1:0] d_i,
    output logic [VW-1:0] pr_o,
    output logic          qbit_o
);
    // The shifted remainder needs VW+1 bits so the compare cannot overflow.
    logic [VW:0] t;

    assign t      = {pr_i, din_i};
    assign qbit_o = (t >= {1'b0, d_i});
    // When t >= d the true difference is < d, so it fits in VW bits and the
    // modulo-2^VW subtraction of the low bits yields it exactly.
    assign pr_o   = qbit_o ? (t[VW-1:0] - d_i) : t[VW-1:0];
endmodule

// File: rtl/serialdiv.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; aborts any operation in flight
//   bus    serialdiv_if slave: start/a/b in, busy/done/q/r/dz out
// Latency start->done is DW+1 cycles for b != 0 and 1 cycle for b == 0.
// Every output comes straight from a register.
module serialdiv
    import arith_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic        clk,
    input  logic        rst_n,
    serialdiv_if.slave  bus
);
    localparam int CW = $clog2(DW);

    div_state_t    state_q;
    logic [DW-1:0] dv_q;
    logic [VW-1:0] d_q;
    logic [VW-1:0] pr_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] q_q;
    logic [VW-1:0] r_q;
    logic          dz_q;
    logic          busy_q;
    logic          done_q;

    logic [VW-1:0] pr_d;
    logic          qbit_d;
    logic [DW-1:0] dv_d;

    divstep #(.VW(VW)) u_step (
        .pr_i   (pr_q),
        .din_i  (dv_q[DW-1]),
        .d_i    (d_q),
        .pr_o   (pr_d),
        .qbit_o (qbit_d)
    );

    // Quotient bits enter at the LSB as dividend bits leave at the MSB, so
    // after DW steps dv holds the complete quotient.
    assign dv_d = {dv_q[DW-2:0], qbit_d};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dv_q    <= '0;
            d_q     <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.b != '0) begin
                            dv_q    <= bus.a;
                            d_q     <= bus.b;
                            pr_q    <= '0;
                            cnt_q   <= '0;
                            q_q     <= '0;
                            r_q     <= '0;
                            dz_q    <= 1'b0;
                            state_q <= RUN;
                        end else begin
                            q_q     <= '1;
                            r_q     <= '0;
                            dz_q    <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    pr_q  <= pr_d;
                    dv_q  <= dv_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DW - 1)) begin
                        q_q     <= dv_d;
                        r_q     <= pr_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // busy stays high through the done cycle and drops with it.
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.dz   = dz_q;
endmodule

// File: tb/tb_serialdiv.sv
// Scoreboard bench for serialdiv: the driver queues the expected result and
// completion cycle for each request; a monitor compares on every done pulse.
module tb_serialdiv;
    localparam int DW = arith_pkg::DIV_DW;
    localparam int VW = arith_pkg::DIV_VW;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
        int unsigned   cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];

    serialdiv_if #(.DW(DW), .VW(VW)) bus ();

    serialdiv #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: one pop per done pulse; a pulse with nothing queued is an error.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("q", 32'(bus.q), 32'(e.q));
                check("r", 32'(bus.r), 32'(e.r));
                check("dz", 32'(bus.dz), 32'(e.dz));
                check("latency", cyc, e.cyc);
                if (e.b != '0) begin
                    ok = ((32'(bus.q) * 32'(e.b) + 32'(bus.r)) == 32'(e.a)) && (bus.r < e.b);
                    check("invariant", 32'(ok), 32'd1);
                end
            end
        end
    end

    // Issue a request at a falling edge; it is sampled at the next rising edge T.
    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input logic [DW-1:0] q, input logic [VW-1:0] r, input logic dz);
        exp_t e;
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz;
        // done is visible after edge T+DW+1 (normal) or T+1 (divide by zero).
        e.cyc = cyc + 1 + ((b == '0) ? 1 : DW + 1);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_rise", 32'(bus.busy), 32'd1);
        if (b != '0) begin
            check("accept_clears_q", 32'(bus.q), 32'd0);
            check("accept_clears_dz", 32'(bus.dz), 32'd0);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 required=1 (cycle %0d)", cyc);
        end
    endtask

    task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input logic [DW-1:0] q, input logic [VW-1:0] r, input logic dz);
        issue(a, b, q, r, dz);
        wait_done();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_dz"}, 32'(bus.dz), 32'd0);
        check({tag, "_q"}, 32'(bus.q), 32'd0);
        check({tag, "_r"}, 32'(bus.r), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [VW-1:0] rb;
        int            n;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Directed vectors.
        run_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        run_div(16'hFFFF, 8'hFF, 16'd257, 8'd0, 1'b0);
        run_div(16'hABCD, 8'd1, 16'hABCD, 8'd0, 1'b0);
        run_div(16'd5, 8'd9, 16'd0, 8'd5, 1'b0);
        run_div(16'd0, 8'd3, 16'd0, 8'd0, 1'b0);
        run_div(16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1);
        run_div(16'd100, 8'd10, 16'd10, 8'd0, 1'b0);

        // A second start during RUN must be ignored and produce no done.
        issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        repeat (3) @(negedge clk);
        bus.a     = 16'd999;
        bus.b     = 8'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (25) @(negedge clk);

        // Reset mid-RUN discards the operation.
        issue(16'd4321, 8'd13, 16'd332, 8'd5, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        check_zero_outputs("midrun_reset");
        repeat (25) @(negedge clk);
        run_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);

        // Random sweep against a division model.
        for (int i = 0; i < 1500; i++) begin
            ra = DW'($urandom_range(0, (1 << DW) - 1));
            rb = VW'($urandom_range(1, (1 << VW) - 1));
            run_div(ra, rb, ra / DW'(rb), VW'(ra % DW'(rb)), 1'b0);
        end

        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
